fir_mac_engine: RTL and testbench

FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_mac_unit.sv | 66 ++++++
 rtl/fir_mac_engine.sv | 163 ++++++++++++++++
 tb/tb_fir_mac_engine.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR multiply-accumulate engine: FSM states,
// datapath width and the BRAM word-to-byte address shift.
package fir_pkg;

    localparam int DATA_W     = 32;
    localparam int BYTE_SHIFT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_IN,
        MAC,
        OUT,
        DONE
    } fir_state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate datapath of the FIR engine.
// Define FIR_SAT_EN for 64-bit accumulation with a saturated 32-bit result.
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_acc_en,
    input  logic signed [DATA_W-1:0] i_tap,
    input  logic signed [DATA_W-1:0] i_data,
    output logic        [DATA_W-1:0] o_result
);

`ifdef FIR_SAT_EN
    localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

    logic signed [63:0] r_acc;
    logic signed [63:0] w_tapExt;
    logic signed [63:0] w_dataExt;
    logic signed [63:0] w_prod;

    assign w_tapExt  = {{32{i_tap[DATA_W-1]}}, i_tap};
    assign w_dataExt = {{32{i_data[DATA_W-1]}}, i_data};
    assign w_prod    = w_tapExt * w_dataExt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + w_prod;
        end
    end

    // Clamp only the presented result; the wide accumulator keeps full range.
    always_comb begin
        o_result = r_acc[DATA_W-1:0];
        if (r_acc > SAT_MAX) begin
            o_result = 32'h7FFF_FFFF;
        end else if (r_acc < SAT_MIN) begin
            o_result = 32'h8000_0000;
        end
    end
`else
    logic signed [DATA_W-1:0] r_acc;
    logic signed [DATA_W-1:0] w_prod;

    assign w_prod = i_tap * i_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + w_prod;
        end
    end

    assign o_result = r_acc;
`endif

endmodule

// File: rtl/fir_mac_engine.sv
// FIR filter engine: circular sample buffer and tap table in external BRAMs,
// AXI-Stream in/out. FIR_SAT_EN selects saturating accumulation.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int NUM_TAP = 11,
    parameter int ADDR_W  = 12
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              ap_start,
    input  logic [31:0]       data_length,
    output logic              ap_idle,
    output logic              ap_done,
    input  logic              ss_tvalid,
    input  logic [DATA_W-1:0] ss_tdata,
    output logic              ss_tready,
    output logic              sm_tvalid,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast,
    input  logic              sm_tready,
    output logic              tap_EN,
    output logic [ADDR_W-1:0] tap_A,
    input  logic [DATA_W-1:0] tap_Do,
    output logic              data_EN,
    output logic [3:0]        data_WE,
    output logic [ADDR_W-1:0] data_A,
    output logic [DATA_W-1:0] data_Di,
    input  logic [DATA_W-1:0] data_Do
);

    localparam int               IDX_W    = $clog2(NUM_TAP + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAP - 1);
    localparam logic [IDX_W-1:0] MAC_END  = IDX_W'(NUM_TAP);

    fir_state_t        r_state;
    fir_state_t        w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_wptr;
    logic [31:0]       r_len;
    logic [31:0]       r_sampleCnt;
    logic [IDX_W-1:0]  w_rdIdx;
    logic              w_start;
    logic              w_accept;
    logic              w_last;
    logic              w_accEn;
    logic [DATA_W-1:0] w_result;

    function automatic logic [ADDR_W-1:0] toByte(input logic [IDX_W-1:0] idx);
        return ADDR_W'(idx) << BYTE_SHIFT;
    endfunction

    assign w_start  = ap_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept = (r_state == WAIT_IN) && ss_tvalid;
    assign w_last   = (r_sampleCnt == r_len - 32'd1);
    assign w_accEn  = (r_state == MAC) && (r_idx != '0);
    // Newest sample minus tap index, wrapped inside the circular buffer.
    assign w_rdIdx  = (r_wptr >= r_idx) ? (r_wptr - r_idx) : (r_wptr + MAC_END - r_idx);
    assign ap_idle  = (r_state == IDLE);
    assign ap_done  = (r_state == DONE);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tdata  = '0;
        sm_tlast  = 1'b0;
        tap_EN    = 1'b0;
        tap_A     = '0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        data_Di   = '0;
        case (r_state)
            IDLE: begin
                if (ap_start) w_next = CLEAR;
            end
            CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = toByte(r_idx);
                if (r_idx == LAST_IDX) w_next = (r_len == 32'd0) ? DONE : WAIT_IN;
            end
            WAIT_IN: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = toByte(r_wptr);
                    data_Di = ss_tdata;
                    w_next  = MAC;
                end
            end
            MAC: begin
                // The final cycle issues no read; it only absorbs the last product.
                if (r_idx != MAC_END) begin
                    tap_EN  = 1'b1;
                    data_EN = 1'b1;
                    tap_A   = toByte(r_idx);
                    data_A  = toByte(w_rdIdx);
                end else begin
                    w_next = OUT;
                end
            end
            OUT: begin
                sm_tvalid = 1'b1;
                sm_tdata  = w_result;
                sm_tlast  = w_last;
                if (sm_tready) w_next = w_last ? DONE : WAIT_IN;
            end
            DONE: begin
                if (ap_start) w_next = CLEAR;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_idx       <= '0;
            r_wptr      <= '0;
            r_len       <= '0;
            r_sampleCnt <= '0;
        end else if (w_start) begin
            r_idx       <= '0;
            r_wptr      <= '0;
            r_len       <= data_length;
            r_sampleCnt <= '0;
        end else begin
            case (r_state)
                CLEAR:   r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                WAIT_IN: if (ss_tvalid) r_idx <= '0;
                MAC:     r_idx <= (r_idx == MAC_END) ? '0 : r_idx + 1'b1;
                OUT: begin
                    if (sm_tready) begin
                        r_wptr      <= (r_wptr == LAST_IDX) ? '0 : r_wptr + 1'b1;
                        r_sampleCnt <= r_sampleCnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    fir_mac_unit u_mac (
        .clk      (axis_clk),
        .rst_n    (axis_rst_n),
        .i_clr    (w_accept),
        .i_acc_en (w_accEn),
        .i_tap    (tap_Do),
        .i_data   (data_Do),
        .o_result (w_result)
    );

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine with behavioural BRAMs and an
// arithmetic FIR reference model (honours FIR_SAT_EN when defined).
module tb_fir_mac_engine;

    localparam int NUM_TAP = 11;
    localparam int ADDR_W  = 12;

    logic              axis_clk = 1'b0;
    logic              axis_rst_n;
    logic              ap_start;
    logic [31:0]       data_length;
    logic              ap_idle;
    logic              ap_done;
    logic              ss_tvalid;
    logic [31:0]       ss_tdata;
    logic              ss_tready;
    logic              sm_tvalid;
    logic [31:0]       sm_tdata;
    logic              sm_tlast;
    logic              sm_tready;
    logic              tap_EN;
    logic [ADDR_W-1:0] tap_A;
    logic [31:0]       tap_Do;
    logic              data_EN;
    logic [3:0]        data_WE;
    logic [ADDR_W-1:0] data_A;
    logic [31:0]       data_Di;
    logic [31:0]       data_Do;

    logic [31:0] tapMem  [0:1023];
    logic [31:0] dataMem [0:1023];
    logic [31:0] h [NUM_TAP];
    logic [31:0] xs [$];
    logic [31:0] gotQ [$];
    int testsRun  = 0;
    int failCount = 0;

    always #5 axis_clk = ~axis_clk;

    fir_mac_engine #(.NUM_TAP(NUM_TAP), .ADDR_W(ADDR_W)) dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .ap_start    (ap_start),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .ss_tvalid   (ss_tvalid),
        .ss_tdata    (ss_tdata),
        .ss_tready   (ss_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tdata    (sm_tdata),
        .sm_tlast    (sm_tlast),
        .sm_tready   (sm_tready),
        .tap_EN      (tap_EN),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do),
        .data_EN     (data_EN),
        .data_WE     (data_WE),
        .data_A      (data_A),
        .data_Di     (data_Di),
        .data_Do     (data_Do)
    );

    // Byte-addressed BRAMs with one cycle of read latency.
    always @(posedge axis_clk) begin
        if (tap_EN) tap_Do <= tapMem[tap_A >> 2];
        if (data_EN) begin
            data_Do <= dataMem[data_A >> 2];
            for (int b = 0; b < 4; b++)
                if (data_WE[b]) dataMem[data_A >> 2][8*b +: 8] <= data_Di[8*b +: 8];
        end
    end

    function automatic logic [31:0] refOut(input int n);
        longint acc;
        acc = 0;
        for (int i = 0; i < NUM_TAP; i++)
            if (n - i >= 0)
                acc += longint'($signed(h[i])) * longint'($signed(xs[n - i]));
`ifdef FIR_SAT_EN
        if (acc > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (acc < -64'sh8000_0000) return 32'h8000_0000;
`endif
        return acc[31:0];
    endfunction

    task automatic loadTaps();
        for (int i = 0; i < NUM_TAP; i++) tapMem[i] = h[i];
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int len, input int stallPct, input bit forceStall, input bit pokeStart);
        int inIdx;
        int outIdx;
        int cycles;
        int stallLeft;
        int pokeState;
        gotQ.delete();
        @(negedge axis_clk);
        data_length = len;
        ap_start    = 1'b1;
        @(negedge axis_clk);
        ap_start = 1'b0;
        checkOutput("doneCleared", {31'b0, ap_done}, 0);
        checkOutput("busyNotIdle", {31'b0, ap_idle}, 0);
        inIdx     = 0;
        outIdx    = 0;
        cycles    = 0;
        stallLeft = forceStall ? 5 : 0;
        pokeState = 0;
        while (!(outIdx == len && ap_done) && cycles < 4000) begin
            ss_tvalid = (inIdx < len);
            ss_tdata  = (inIdx < len) ? xs[inIdx] : 32'h0;
            if (pokeState == 1) begin
                ap_start  = 1'b1;
                pokeState = 2;
            end else begin
                ap_start = 1'b0;
            end
            if (sm_tvalid && stallLeft > 0) begin
                sm_tready = 1'b0;
                stallLeft--;
            end else begin
                sm_tready = ($urandom_range(99) >= stallPct);
            end
            if (ss_tvalid && ss_tready) begin
                inIdx++;
                if (pokeStart && pokeState == 0) pokeState = 1;
            end
            if (sm_tvalid) begin
                checkOutput("outQuiet", {28'b0, ss_tready, tap_EN, data_EN, |data_WE}, 0);
                if (outIdx < len) begin
                    checkOutput($sformatf("y[%0d]", outIdx), sm_tdata, refOut(outIdx));
                    checkOutput($sformatf("tlast[%0d]", outIdx), {31'b0, sm_tlast},
                                {31'b0, outIdx == len - 1});
                end else begin
                    checkOutput("extraOut", {31'b0, sm_tvalid}, 0);
                end
                if (sm_tready) begin
                    gotQ.push_back(sm_tdata);
                    outIdx++;
                end
            end
            @(negedge axis_clk);
            cycles++;
        end
        ss_tvalid = 1'b0;
        sm_tready = 1'b0;
        ap_start  = 1'b0;
        checkOutput("noTimeout", {31'b0, cycles < 4000}, 1);
        checkOutput("inCount", inIdx, len);
        checkOutput("outCount", outIdx, len);
        checkOutput("apDone", {31'b0, ap_done}, 1);
        checkOutput("doneNotIdle", {31'b0, ap_idle}, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        logic [31:0] expConst;
        axis_rst_n  = 1'b1;
        ap_start    = 1'b0;
        data_length = 32'd0;
        ss_tvalid   = 1'b0;
        ss_tdata    = 32'd0;
        sm_tready   = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            tapMem[i]  = $urandom;
            dataMem[i] = $urandom;
        end
        #2 axis_rst_n = 1'b0;
        #3;
        checkOutput("rstIdle", {31'b0, ap_idle}, 1);
        checkOutput("rstDone", {31'b0, ap_done}, 0);
        checkOutput("rstStreams", {29'b0, ss_tready, sm_tvalid, sm_tlast}, 0);
        checkOutput("rstTdata", sm_tdata, 0);
        checkOutput("rstBram", {26'b0, tap_EN, data_EN, data_WE}, 0);
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;

        // All-ones taps: running sum of 1..5.
        for (int i = 0; i < NUM_TAP; i++) h[i] = 32'd1;
        loadTaps();
        xs = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        applyStimulus(5, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            expConst = 32'(k + 1) * 32'(k + 2) / 32'd2;
            checkOutput($sformatf("sumConst[%0d]", k), gotQ[k], expConst);
        end

        // Impulse response with a forced 5-cycle output stall.
        for (int i = 0; i < NUM_TAP; i++) h[i] = 32'(i);
        loadTaps();
        xs.delete();
        xs.push_back(32'd1);
        for (int i = 0; i < 11; i++) xs.push_back(32'd0);
        applyStimulus(12, 30, 1, 0);
        for (int k = 0; k < 12; k++) begin
            expConst = (k <= 10) ? 32'(k) : 32'd0;
            checkOutput($sformatf("impulse[%0d]", k), gotQ[k], expConst);
        end

        // Start pulse during MAC is ignored; a second run starts from DONE.
        for (int i = 0; i < NUM_TAP; i++) h[i] = $urandom;
        loadTaps();
        xs.delete();
        for (int i = 0; i < 6; i++) xs.push_back($urandom);
        applyStimulus(6, 20, 0, 1);
        xs.delete();
        for (int i = 0; i < 3; i++) xs.push_back($urandom);
        applyStimulus(3, 20, 0, 0);
        expConst = h[0] * xs[0];
`ifdef FIR_SAT_EN
        expConst = refOut(0);
`endif
        checkOutput("secondRunFirst", gotQ[0], expConst);

        // Zero-length run consumes nothing.
        xs.delete();
        applyStimulus(0, 0, 0, 0);

        // Randomised runs with mixed tap magnitudes and back-pressure.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_TAP; i++)
                h[i] = (r[0]) ? $urandom : 32'($signed($urandom_range(200)) - 100);
            loadTaps();
            xs.delete();
            for (int i = 0; i < 20; i++) xs.push_back((r[1]) ? $urandom : 32'($urandom_range(1000)));
            applyStimulus($urandom_range(20, 1), 40, 0, 0);
        end

        // Reset asserted mid-MAC abandons the run.
        xs.delete();
        for (int i = 0; i < 4; i++) xs.push_back($urandom);
        @(negedge axis_clk);
        data_length = 32'd4;
        ap_start    = 1'b1;
        @(negedge axis_clk);
        ap_start  = 1'b0;
        ss_tvalid = 1'b1;
        ss_tdata  = xs[0];
        cycles    = 0;
        while (!ss_tready && cycles < 100) begin
            @(negedge axis_clk);
            cycles++;
        end
        checkOutput("rstRunAccept", {31'b0, cycles < 100}, 1);
        @(negedge axis_clk);
        ss_tvalid = 1'b0;
        @(negedge axis_clk);
        axis_rst_n = 1'b0;
        #1;
        checkOutput("midRstIdle", {31'b0, ap_idle}, 1);
        checkOutput("midRstOuts", {28'b0, ap_done, ss_tready, sm_tvalid, sm_tlast}, 0);
        checkOutput("midRstTdata", sm_tdata, 0);
        checkOutput("midRstBram", {26'b0, tap_EN, data_EN, data_WE}, 0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        sm_tready  = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge axis_clk);
            checkOutput("postRstQuiet", {30'b0, sm_tvalid, ~ap_idle}, 0);
        end
        sm_tready = 1'b0;

        // Large taps: wrapped vs saturated result.
        for (int i = 0; i < NUM_TAP; i++) h[i] = 32'h7FFF_FFFF;
        loadTaps();
        xs = '{32'd2, 32'd2};
        applyStimulus(2, 0, 0, 0);
`ifdef FIR_SAT_EN
        checkOutput("bigTap0", gotQ[0], 32'h7FFF_FFFF);
        checkOutput("bigTap1", gotQ[1], 32'h7FFF_FFFF);
`else
        checkOutput("bigTap0", gotQ[0], 32'hFFFF_FFFE);
        checkOutput("bigTap1", gotQ[1], 32'hFFFF_FFFC);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
